// File: rtl/instruction_decode_stage.sv
// MIPS decode stage: field slicing, control decode, 32x32 register file with
// write-through bypass, load-use stall detection and the ID/EX pipeline register.
module instruction_decode_stage (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] instruction_in,
    input  logic        flush,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        wb_write_enable,
    input  logic [4:0]  wb_reg_addr,
    input  logic [31:0] wb_data,
    output logic        PC_write_enable,
    output logic        id_ex_valid,
    output logic        id_ex_illegal,
    output logic [4:0]  id_ex_rs,
    output logic [4:0]  id_ex_rt,
    output logic [4:0]  id_ex_rd,
    output logic [4:0]  id_ex_shamt,
    output logic [31:0] id_ex_rs_data,
    output logic [31:0] id_ex_rt_data,
    output logic [31:0] id_ex_imm_ext,
    output logic        id_ex_reg_write,
    output logic        id_ex_mem_read,
    output logic        id_ex_mem_write,
    output logic        id_ex_alu_src,
    output logic        id_ex_reg_dst,
    output logic        id_ex_mem_to_reg,
    output logic        id_ex_branch,
    output logic        id_ex_branch_ne,
    output logic [3:0]  id_ex_alu_op
);

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2,
                           ALU_OR  = 4'd3, ALU_SLT = 4'd4, ALU_NOR = 4'd5,
                           ALU_SLL = 4'd6, ALU_SRL = 4'd7, ALU_XOR = 4'd8;

    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm_ext;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        alu_src;
        logic        reg_dst;
        logic        mem_to_reg;
        logic        branch;
        logic        branch_ne;
        logic [3:0]  alu_op;
    } id_ex_t;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;

    assign opcode = instruction_in[31:26];
    assign rs     = instruction_in[25:21];
    assign rt     = instruction_in[20:16];
    assign rd     = instruction_in[15:11];
    assign shamt  = instruction_in[10:6];
    assign funct  = instruction_in[5:0];
    assign imm    = instruction_in[15:0];

    logic       legal, rt_src, zext;
    logic       c_reg_write, c_mem_read, c_mem_write, c_alu_src;
    logic       c_reg_dst, c_mem_to_reg, c_branch, c_branch_ne;
    logic [3:0] c_alu_op;

    always_comb begin
        legal        = 1'b1;
        rt_src       = 1'b0;
        zext         = 1'b0;
        c_reg_write  = 1'b0;
        c_mem_read   = 1'b0;
        c_mem_write  = 1'b0;
        c_alu_src    = 1'b0;
        c_reg_dst    = 1'b0;
        c_mem_to_reg = 1'b0;
        c_branch     = 1'b0;
        c_branch_ne  = 1'b0;
        c_alu_op     = ALU_ADD;
        case (opcode)
            6'h00: begin
                c_reg_write = 1'b1;
                c_reg_dst   = 1'b1;
                rt_src      = 1'b1;
                case (funct)
                    6'h20:   c_alu_op = ALU_ADD;
                    6'h22:   c_alu_op = ALU_SUB;
                    6'h24:   c_alu_op = ALU_AND;
                    6'h25:   c_alu_op = ALU_OR;
                    6'h26:   c_alu_op = ALU_XOR;
                    6'h27:   c_alu_op = ALU_NOR;
                    6'h2A:   c_alu_op = ALU_SLT;
                    6'h00:   c_alu_op = ALU_SLL;
                    6'h02:   c_alu_op = ALU_SRL;
                    default: legal    = 1'b0;
                endcase
            end
            6'h08: begin c_reg_write = 1'b1; c_alu_src = 1'b1; end
            6'h0A: begin c_reg_write = 1'b1; c_alu_src = 1'b1; c_alu_op = ALU_SLT; end
            6'h0C: begin c_reg_write = 1'b1; c_alu_src = 1'b1; c_alu_op = ALU_AND; zext = 1'b1; end
            6'h0D: begin c_reg_write = 1'b1; c_alu_src = 1'b1; c_alu_op = ALU_OR;  zext = 1'b1; end
            6'h23: begin
                c_reg_write  = 1'b1;
                c_alu_src    = 1'b1;
                c_mem_read   = 1'b1;
                c_mem_to_reg = 1'b1;
            end
            6'h2B: begin c_mem_write = 1'b1; c_alu_src = 1'b1; rt_src = 1'b1; end
            6'h04: begin c_branch = 1'b1; c_alu_op = ALU_SUB; rt_src = 1'b1; end
            6'h05: begin
                c_branch    = 1'b1;
                c_branch_ne = 1'b1;
                c_alu_op    = ALU_SUB;
                rt_src      = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    // Register file; $0 is never written and always reads zero
    logic [31:0] regs [32];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_write_enable && wb_reg_addr != 5'd0) begin
            regs[wb_reg_addr] <= wb_data;
        end
    end

    logic [31:0] rs_data, rt_data;

    // Same-cycle write-back is forwarded so the decode sees the new value
    always_comb begin
        rs_data = regs[rs];
        rt_data = regs[rt];
        if (wb_write_enable && wb_reg_addr == rs) rs_data = wb_data;
        if (wb_write_enable && wb_reg_addr == rt) rt_data = wb_data;
        if (rs == 5'd0) rs_data = '0;
        if (rt == 5'd0) rt_data = '0;
    end

    logic hazard, stall;

    assign hazard = legal && ex_mem_read && ex_rt != 5'd0 &&
                    (ex_rt == rs || (ex_rt == rt && rt_src));
    assign stall  = hazard && !flush;
    assign PC_write_enable = !RESET || !stall;

    id_ex_t idex_q, idex_d;

    always_comb begin
        idex_d = '0;
        if (!flush && !stall) begin
            if (!legal) begin
                idex_d.illegal = 1'b1;
            end else begin
                idex_d.valid      = 1'b1;
                idex_d.rs         = rs;
                idex_d.rt         = rt;
                idex_d.rd         = rd;
                idex_d.shamt      = shamt;
                idex_d.rs_data    = rs_data;
                idex_d.rt_data    = rt_data;
                idex_d.imm_ext    = zext ? {16'h0, imm} : {{16{imm[15]}}, imm};
                idex_d.reg_write  = c_reg_write;
                idex_d.mem_read   = c_mem_read;
                idex_d.mem_write  = c_mem_write;
                idex_d.alu_src    = c_alu_src;
                idex_d.reg_dst    = c_reg_dst;
                idex_d.mem_to_reg = c_mem_to_reg;
                idex_d.branch     = c_branch;
                idex_d.branch_ne  = c_branch_ne;
                idex_d.alu_op     = c_alu_op;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) idex_q <= '0;
        else        idex_q <= idex_d;
    end

    assign id_ex_valid      = idex_q.valid;
    assign id_ex_illegal    = idex_q.illegal;
    assign id_ex_rs         = idex_q.rs;
    assign id_ex_rt         = idex_q.rt;
    assign id_ex_rd         = idex_q.rd;
    assign id_ex_shamt      = idex_q.shamt;
    assign id_ex_rs_data    = idex_q.rs_data;
    assign id_ex_rt_data    = idex_q.rt_data;
    assign id_ex_imm_ext    = idex_q.imm_ext;
    assign id_ex_reg_write  = idex_q.reg_write;
    assign id_ex_mem_read   = idex_q.mem_read;
    assign id_ex_mem_write  = idex_q.mem_write;
    assign id_ex_alu_src    = idex_q.alu_src;
    assign id_ex_reg_dst    = idex_q.reg_dst;
    assign id_ex_mem_to_reg = idex_q.mem_to_reg;
    assign id_ex_branch     = idex_q.branch;
    assign id_ex_branch_ne  = idex_q.branch_ne;
    assign id_ex_alu_op     = idex_q.alu_op;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Directed bench for instruction_decode_stage: expected ID/EX contents are
// queued when an instruction is presented and compared one cycle later.
module tb_instruction_decode_stage;

    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm_ext;
        logic [7:0]  ctl;    // reg_write,mem_read,mem_write,alu_src,reg_dst,mem_to_reg,branch,branch_ne
        logic [3:0]  alu_op;
    } idex_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] instruction_in;
    logic        flush, ex_mem_read, wb_write_enable;
    logic [4:0]  ex_rt, wb_reg_addr;
    logic [31:0] wb_data;
    logic        PC_write_enable;
    logic        id_ex_valid, id_ex_illegal;
    logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd, id_ex_shamt;
    logic [31:0] id_ex_rs_data, id_ex_rt_data, id_ex_imm_ext;
    logic        id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_alu_src;
    logic        id_ex_reg_dst, id_ex_mem_to_reg, id_ex_branch, id_ex_branch_ne;
    logic [3:0]  id_ex_alu_op;

    always #5 CLK = ~CLK;

    instruction_decode_stage dut (
        .CLK(CLK), .RESET(RESET), .instruction_in(instruction_in), .flush(flush),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .wb_write_enable(wb_write_enable), .wb_reg_addr(wb_reg_addr), .wb_data(wb_data),
        .PC_write_enable(PC_write_enable),
        .id_ex_valid(id_ex_valid), .id_ex_illegal(id_ex_illegal),
        .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd), .id_ex_shamt(id_ex_shamt),
        .id_ex_rs_data(id_ex_rs_data), .id_ex_rt_data(id_ex_rt_data), .id_ex_imm_ext(id_ex_imm_ext),
        .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read),
        .id_ex_mem_write(id_ex_mem_write), .id_ex_alu_src(id_ex_alu_src),
        .id_ex_reg_dst(id_ex_reg_dst), .id_ex_mem_to_reg(id_ex_mem_to_reg),
        .id_ex_branch(id_ex_branch), .id_ex_branch_ne(id_ex_branch_ne),
        .id_ex_alu_op(id_ex_alu_op)
    );

    idex_t obs;
    assign obs = {id_ex_valid, id_ex_illegal, id_ex_rs, id_ex_rt, id_ex_rd, id_ex_shamt,
                  id_ex_rs_data, id_ex_rt_data, id_ex_imm_ext,
                  id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_alu_src,
                  id_ex_reg_dst, id_ex_mem_to_reg, id_ex_branch, id_ex_branch_ne,
                  id_ex_alu_op};

    idex_t exp_q[$];
    string tag_q[$];
    int    total = 0;
    int    passed = 0;

    localparam idex_t BUBBLE = '0;

    function automatic idex_t mk(input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [4:0] sh,
                                 input logic [31:0] rsd, input logic [31:0] rtd,
                                 input logic [31:0] imm, input logic [7:0] ctl,
                                 input logic [3:0] op);
        idex_t e;
        e = '0;
        e.valid = 1'b1;
        e.rs = rs; e.rt = rt; e.rd = rd; e.shamt = sh;
        e.rs_data = rsd; e.rt_data = rtd; e.imm_ext = imm;
        e.ctl = ctl; e.alu_op = op;
        return e;
    endfunction

    task automatic chk_idex(input string tag, input idex_t e);
        total++;
        assert (obs === e) passed++;
        else $error("FAIL %s: id_ex observed=%h expected=%h", tag, obs, e);
    endtask

    task automatic chk_pc(input string tag, input logic e);
        total++;
        assert (PC_write_enable === e) passed++;
        else $error("FAIL %s: PC_write_enable observed=%b expected=%b", tag, PC_write_enable, e);
    endtask

    task automatic present(input string tag, input logic [31:0] instr, input idex_t e);
        instruction_in = instr;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
        wb_write_enable = en; wb_reg_addr = a; wb_data = d;
    endtask

    // Clock one edge, then compare the oldest queued expectation
    task automatic tick();
        @(posedge CLK);
        #1;
        if (exp_q.size() != 0) chk_idex(tag_q.pop_front(), exp_q.pop_front());
    endtask

    initial begin
        RESET = 1'b0; instruction_in = '0; flush = 1'b0;
        ex_mem_read = 1'b0; ex_rt = '0; wb(1'b0, 5'd0, 32'h0);
        #3;
        chk_idex("reset_state", BUBBLE);
        chk_pc("reset_pc", 1'b1);
        @(negedge CLK); RESET = 1'b1;
        @(posedge CLK); #1;

        // addi $8,$0,-5 with $8 written back in the same cycle
        wb(1'b1, 5'd8, 32'hFFFF_FFFB);
        present("addi", 32'h2008FFFB,
                mk(5'd0, 5'd8, 5'd31, 5'd31, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 8'b1001_0000, 4'd0));
        tick();
        wb(1'b0, 5'd0, 32'h0);
        present("andi_zext", 32'h3109FFFF,
                mk(5'd8, 5'd9, 5'd31, 5'd31, 32'hFFFF_FFFB, 32'h0, 32'h0000_FFFF, 8'b1001_0000, 4'd2));
        tick();
        begin
            idex_t e; e = '0; e.illegal = 1'b1;
            present("illegal_opcode", 32'hFC000000, e);
            tick();
            present("illegal_funct", 32'h00000001, e);
            tick();
        end

        wb(1'b1, 5'd9, 32'h1234_5678);
        present("write_through", 32'h01295020,
                mk(5'd9, 5'd9, 5'd10, 5'd0, 32'h1234_5678, 32'h1234_5678, 32'h0000_5020, 8'b1000_1000, 4'd0));
        tick();

        // Load-use stall on rs=$8; a write-back during the stall must still land
        wb(1'b1, 5'd11, 32'hA5A5_A5A5);
        ex_mem_read = 1'b1; ex_rt = 5'd8;
        present("stall_bubble", 32'h01095020, BUBBLE);
        #1 chk_pc("stall_pc", 1'b0);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        ex_mem_read = 1'b0;
        present("after_stall", 32'h01095020,
                mk(5'd8, 5'd9, 5'd10, 5'd0, 32'hFFFF_FFFB, 32'h1234_5678, 32'h0000_5020, 8'b1000_1000, 4'd0));
        #1 chk_pc("resume_pc", 1'b1);
        tick();
        ex_mem_read = 1'b1; flush = 1'b1;
        present("flush_over_stall", 32'h01095020, BUBBLE);
        #1 chk_pc("flush_pc", 1'b1);
        tick();
        ex_mem_read = 1'b0;
        present("flush_illegal", 32'hFC000000, BUBBLE);
        tick();
        flush = 1'b0;

        // addi only reads rs, so a load into its rt is not a hazard
        ex_mem_read = 1'b1; ex_rt = 5'd8;
        present("rt_not_source", 32'h2008FFFB,
                mk(5'd0, 5'd8, 5'd31, 5'd31, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 8'b1001_0000, 4'd0));
        #1 chk_pc("rt_not_source_pc", 1'b1);
        tick();
        ex_rt = 5'd9;
        present("sw_rt_hazard", 32'hAD090000, BUBBLE);
        #1 chk_pc("sw_rt_hazard_pc", 1'b0);
        tick();
        ex_mem_read = 1'b0; ex_rt = 5'd0;

        present("lw", 32'h8D6C0004,
                mk(5'd11, 5'd12, 5'd0, 5'd0, 32'hA5A5_A5A5, 32'h0, 32'h4, 8'b1101_0100, 4'd0));
        tick();
        wb(1'b1, 5'd5, 32'hDEAD_BEEF);
        present("bne", 32'h1509FFFF,
                mk(5'd8, 5'd9, 5'd31, 5'd31, 32'hFFFF_FFFB, 32'h1234_5678, 32'hFFFF_FFFF, 8'b0000_0011, 4'd1));
        tick();

        wb(1'b1, 5'd0, 32'hFFFF_FFFF);
        present("zero_bypass", 32'h00000820,
                mk(5'd0, 5'd0, 5'd1, 5'd0, 32'h0, 32'h0, 32'h0000_0820, 8'b1000_1000, 4'd0));
        tick();
        wb(1'b0, 5'd0, 32'h0);
        present("zero_read", 32'h00000820,
                mk(5'd0, 5'd0, 5'd1, 5'd0, 32'h0, 32'h0, 32'h0000_0820, 8'b1000_1000, 4'd0));
        tick();

        // Asynchronous reset in the middle of a stalled cycle
        ex_mem_read = 1'b1; ex_rt = 5'd5;
        instruction_in = 32'h00A53020;
        #1 chk_pc("pre_reset_stall_pc", 1'b0);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk_idex("async_reset", BUBBLE);
        chk_pc("reset_pc_mid_stall", 1'b1);
        @(negedge CLK);
        RESET = 1'b1; ex_mem_read = 1'b0; ex_rt = 5'd0;
        present("reg5_cleared", 32'h00A53020,
                mk(5'd5, 5'd5, 5'd6, 5'd0, 32'h0, 32'h0, 32'h0000_3020, 8'b1000_1000, 4'd0));
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
